// File: rtl/mul_sequencer.sv
// mul_sequencer
// Iterative radix-2 shift-add multiplier for the SPECIAL2 `mul` instruction,
// placed in EX beside the ALU. It captures the operand magnitudes and the
// product sign, then accumulates one partial product per cycle for WIDTH
// cycles while stalling the front of the pipeline. In the final (DONE) cycle
// it presents the signed 2*WIDTH-bit product for one cycle, so the EX/MEM
// register can capture it.
//
// Ports
//   i_clk        clock, rising edge
//   i_rst        synchronous active-high reset
//   i_start      valid `mul` in EX, sampled only in IDLE
//   i_flush      squash: abort the current operation
//   i_a, i_b     rs / rt operands, two's complement
//   i_dest_in    rd of the `mul`
//   o_stall      freezes PC, IF/ID, ID/EX (combinational)
//   o_busy       high in RUN or DONE (registered)
//   o_done       one-cycle product-valid pulse
//   o_result     low WIDTH bits of the product (written to rd)
//   o_result_hi  high WIDTH bits of the product
//   o_dest_out   latched rd, valid while o_done is high
//
// state | meaning
// IDLE  | waiting for i_start; operands captured on the edge that leaves IDLE
// RUN   | one shift-add iteration per cycle, WIDTH iterations in total
// DONE  | product presented for one cycle, then back to IDLE unconditionally

module mul_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic             i_flush,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic [4:0]       i_dest_in,
  output logic             o_stall,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_result,
  output logic [WIDTH-1:0] o_result_hi,
  output logic [4:0]       o_dest_out
);

  localparam int PW = 2 * WIDTH;
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t           r_state;
  logic [PW-1:0]    r_mcand;
  logic [WIDTH-1:0] r_mplier;
  logic [PW-1:0]    r_acc;
  logic [CW-1:0]    r_count;
  logic             r_neg;
  logic [4:0]       r_dest;
  logic             r_busy;
  logic             r_done;
  logic [WIDTH-1:0] r_result;
  logic [WIDTH-1:0] r_result_hi;
  logic [4:0]       r_dest_out;

  logic [WIDTH-1:0] w_abs_a;
  logic [WIDTH-1:0] w_abs_b;
  logic [PW-1:0]    w_partial;
  logic [PW-1:0]    w_prod;
  logic             w_present;

  // The most negative operand negates to 2^(WIDTH-1), which is still a
  // correct unsigned magnitude in WIDTH bits, so no special case is needed.
  assign w_abs_a = i_a[WIDTH-1] ? (~i_a + WIDTH'(1)) : i_a;
  assign w_abs_b = i_b[WIDTH-1] ? (~i_b + WIDTH'(1)) : i_b;

  assign w_partial = r_mplier[0] ? r_mcand : '0;

  assign w_prod = r_neg ? (~r_acc + PW'(1)) : r_acc;

  // A flush landing in the DONE cycle must hide the product and the pulse
  // in that same cycle, so the registered DONE pulse is gated by i_flush and
  // the outputs fall back to the last committed values.
  assign w_present = r_done & ~i_flush;

  assign o_stall = ((r_state == ST_IDLE) & i_start & ~i_flush) |
                   ((r_state == ST_RUN) & ~i_flush);
  assign o_busy      = r_busy;
  assign o_done      = w_present;
  assign o_result    = w_present ? w_prod[WIDTH-1:0]  : r_result;
  assign o_result_hi = w_present ? w_prod[PW-1:WIDTH] : r_result_hi;
  assign o_dest_out  = w_present ? r_dest             : r_dest_out;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= ST_IDLE;
      r_mcand     <= '0;
      r_mplier    <= '0;
      r_acc       <= '0;
      r_count     <= '0;
      r_neg       <= 1'b0;
      r_dest      <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_result    <= '0;
      r_result_hi <= '0;
      r_dest_out  <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (i_start && !i_flush) begin
            r_mcand  <= {{WIDTH{1'b0}}, w_abs_a};
            r_mplier <= w_abs_b;
            r_neg    <= i_a[WIDTH-1] ^ i_b[WIDTH-1];
            r_dest   <= i_dest_in;
            r_acc    <= '0;
            r_count  <= '0;
            r_busy   <= 1'b1;
            r_state  <= ST_RUN;
          end
        end

        ST_RUN: begin
          if (i_flush) begin
            r_busy  <= 1'b0;
            r_state <= ST_IDLE;
          end else begin
            r_acc    <= r_acc + w_partial;
            r_mcand  <= {r_mcand[PW-2:0], 1'b0};
            r_mplier <= {1'b0, r_mplier[WIDTH-1:1]};
            r_count  <= r_count + CW'(1);
            if (r_count == LAST_ITER) begin
              r_done  <= 1'b1;
              r_state <= ST_DONE;
            end
          end
        end

        ST_DONE: begin
          // Start seen here belongs to the retiring instruction.
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
          if (!i_flush) begin
            r_result    <= w_prod[WIDTH-1:0];
            r_result_hi <= w_prod[PW-1:WIDTH];
            r_dest_out  <= r_dest;
          end
        end

        default: begin
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
